// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared state encoding, command-entry layout and default command table
package spi_seq_pkg;
    localparam int P_DATA = 8;
    localparam int P_NCMD = 3;
    localparam int P_MAXB = 8;
    localparam int P_TMO  = 1024;
    localparam int P_NBW  = $clog2(P_MAXB + 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_PUSH, ST_LAUNCH, ST_WAIT_HI, ST_WAIT_LO, ST_DRAIN, ST_NEXT, ST_DONE, ST_ERR
    } state_t;

    typedef struct packed {
        logic                          op;
        logic [15:0]                   len;
        logic [P_NBW-1:0]              nbytes;
        logic [P_MAXB-1:0][P_DATA-1:0] bytes;
    } entry_t;

    // bytes[0] goes out first, so the first TX byte sits in the lowest lane
    localparam entry_t E0 = '{op: 1'b0, len: 16'd40, nbytes: P_NBW'(3), bytes: 64'h0000_0000_0000_1900};
    localparam entry_t E1 = '{op: 1'b1, len: 16'd40, nbytes: P_NBW'(5), bytes: 64'h0000_00a0_0f04_1900};
    localparam entry_t E2 = '{op: 1'b0, len: 16'd40, nbytes: P_NBW'(3), bytes: 64'h0000_0000_0000_1900};
endpackage

// File: rtl/spi_seq_rom.sv
// spi_seq_rom: combinational command table lookup
module spi_seq_rom
    import spi_seq_pkg::*;
#(
    parameter int NCMD = P_NCMD
) (
    input  logic [$clog2(NCMD)-1:0] idx,
    output entry_t                  ent
);
    localparam int IW = $clog2(NCMD);

    assign ent = idx == IW'(1) ? E1 : idx == IW'(2) ? E2 : E0;
endmodule

// File: rtl/spi_seq_fsm.sv
// spi_seq_fsm: walks the command table, feeding the TX FIFO, launching SPI transfers and draining RX data
module spi_seq_fsm
    import spi_seq_pkg::*;
#(
    parameter int DATA = P_DATA,
    parameter int NCMD = P_NCMD,
    parameter int MAXB = P_MAXB,
    parameter int TMO  = P_TMO
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    loop_en,
    output logic [15:0]             len,
    output logic                    op,
    output logic                    work,
    input  logic                    busy,
    output logic [DATA-1:0]         wdata,
    output logic                    wr,
    input  logic                    full,
    input  logic [DATA-1:0]         rdata,
    output logic                    rd,
    input  logic                    empty,
    output logic [DATA-1:0]         rx_data,
    output logic                    rx_valid,
    output logic [$clog2(NCMD)-1:0] cmd_idx,
    output logic                    done,
    output logic                    err
);
    localparam int CW = $clog2(MAXB + 1);
    localparam int BW = $clog2(P_MAXB);
    localparam int TW = $clog2(TMO + 1);
    localparam int IW = $clog2(NCMD);
    localparam logic [15:0] DW = 16'(DATA);

    state_t          state, state_nx;
    entry_t          ent;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [TW-1:0]   tmr, tmr_nx;
    logic [15:0]     rdc, rdc_nx, nrd;
    logic [IW-1:0]   idx_nx;
    logic [DATA-1:0] rx_last;
    logic            pushed, last, tmo_hit;

    spi_seq_rom #(.NCMD(NCMD)) u_rom (.idx(cmd_idx), .ent(ent));

    assign pushed  = cnt == CW'(ent.nbytes);
    assign last    = cmd_idx == IW'(NCMD - 1);
    assign tmo_hit = tmr == TW'(TMO);
    assign nrd     = len / DW;
    assign wr      = state == ST_PUSH && !pushed && !full;
    assign wdata   = state == ST_PUSH && !pushed ? DATA'(ent.bytes[cnt[BW-1:0]]) : '0;
    assign work    = state == ST_LAUNCH;
    assign rd      = state == ST_DRAIN && !empty && rdc < nrd;
    assign done    = state == ST_DONE;
    assign err     = state == ST_ERR;
    // the RX FIFO presents its byte in the cycle after rd, which is when rx_valid is high
    assign rx_data = rx_valid ? rdata : rx_last;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tmr_nx   = '0;
        rdc_nx   = rdc;
        idx_nx   = cmd_idx;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                state_nx = start ? ST_PUSH : state;
                idx_nx   = start ? '0 : cmd_idx;
                cnt_nx   = start ? '0 : cnt;
            end
            ST_PUSH: begin
                cnt_nx   = cnt + CW'(wr);
                state_nx = pushed && !busy ? ST_LAUNCH : ST_PUSH;
            end
            ST_LAUNCH: state_nx = ST_WAIT_HI;
            ST_WAIT_HI: begin
                tmr_nx   = busy ? '0 : tmr + 1'b1;
                state_nx = busy ? ST_WAIT_LO : tmo_hit ? ST_ERR : ST_WAIT_HI;
            end
            ST_WAIT_LO: begin
                tmr_nx   = busy ? tmr + 1'b1 : '0;
                rdc_nx   = '0;
                state_nx = !busy ? (op ? ST_NEXT : ST_DRAIN) : tmo_hit ? ST_ERR : ST_WAIT_LO;
            end
            ST_DRAIN: begin
                tmr_nx   = tmr + 1'b1;
                rdc_nx   = rdc + 16'(rd);
                state_nx = rdc == nrd ? ST_NEXT : tmo_hit ? ST_ERR : ST_DRAIN;
            end
            ST_NEXT: begin
                cnt_nx   = '0;
                idx_nx   = !last ? cmd_idx + 1'b1 : loop_en ? '0 : cmd_idx;
                state_nx = !last || loop_en ? ST_PUSH : ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            tmr      <= '0;
            rdc      <= '0;
            cmd_idx  <= '0;
            len      <= '0;
            op       <= 1'b0;
            rx_valid <= 1'b0;
            rx_last  <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            tmr      <= tmr_nx;
            rdc      <= rdc_nx;
            cmd_idx  <= idx_nx;
            rx_valid <= rd;
            if (state == ST_PUSH && state_nx == ST_LAUNCH) begin
                len <= ent.len;
                op  <= ent.op;
            end
            if (rx_valid)
                rx_last <= rdata;
        end
    end
endmodule

// File: tb/tb_spi_seq_fsm.sv
// tb_spi_seq_fsm: scoreboard bench with SPI controller, TX/RX FIFO models and a table-level reference
`timescale 1ns/1ps
module tb_spi_seq_fsm;
    localparam int TMO = 100;

    logic        clk = 0, rst = 0, start = 0, loop_en = 0, busy = 0, full = 0, empty = 1;
    logic [7:0]  rdata = 0, wdata, rx_data;
    logic [15:0] len;
    logic        op, work, wr, rd, rx_valid, done, err;
    logic [1:0]  cmd_idx;

    spi_seq_fsm #(.TMO(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .loop_en(loop_en), .len(len), .op(op), .work(work),
        .busy(busy), .wdata(wdata), .wr(wr), .full(full), .rdata(rdata), .rd(rd), .empty(empty),
        .rx_data(rx_data), .rx_valid(rx_valid), .cmd_idx(cmd_idx), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, gen = 0, rd_cnt = 0, work_cnt = 0, work_cyc = 0;
    bit hang = 0, emp_rand = 0, full_rand = 0;
    logic [7:0]  exp_wr[$], exp_rx[$], rxq[$];
    logic [16:0] exp_work[$], ctrl_q[$];

    // reference command table, as a plain list of entries
    localparam logic [7:0] TB_B [3][5] = '{'{8'h00, 8'h19, 8'h00, 8'h00, 8'h00},
                                           '{8'h00, 8'h19, 8'h04, 8'h0f, 8'ha0},
                                           '{8'h00, 8'h19, 8'h00, 8'h00, 8'h00}};
    localparam int TB_N [3]  = '{3, 5, 3};
    localparam bit TB_OP [3] = '{1'b0, 1'b1, 1'b0};
    localparam int TB_LEN    = 40;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen where none was required", name);
    endtask

    task automatic expect_entry(input int i);
        for (int j = 0; j < TB_N[i]; j++) exp_wr.push_back(TB_B[i][j]);
        exp_work.push_back({TB_OP[i], 16'(TB_LEN)});
        ctrl_q.push_back({TB_OP[i], 16'(TB_LEN)});
    endtask

    task automatic expect_all();
        for (int i = 0; i < 3; i++) expect_entry(i);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (!done && !err && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) fail({tag, "_end_timeout"});
    endtask

    task automatic wait_work(input int target, input int budget);
        int n = 0;
        while (work_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) fail("work_timeout");
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_len"}, len, 0);           chk({tag, "_op"}, op, 0);
        chk({tag, "_work"}, work, 0);         chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_wr"}, wr, 0);             chk({tag, "_rd"}, rd, 0);
        chk({tag, "_rx_data"}, rx_data, 0);   chk({tag, "_rx_valid"}, rx_valid, 0);
        chk({tag, "_cmd_idx"}, cmd_idx, 0);   chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_wr_left"}, exp_wr.size(), 0);
        chk({tag, "_work_left"}, exp_work.size(), 0);
        chk({tag, "_rx_left"}, exp_rx.size(), 0);
        chk({tag, "_fifo_left"}, rxq.size(), 0);
    endtask

    // SPI controller: busy pulse after each launch; a completed read fills the RX FIFO with len/8 bytes
    initial begin : ctrl
        int d, g;
        logic [16:0] c;
        forever begin
            @(negedge clk);
            if (rst && work) begin
                c = 17'h10000;
                if (ctrl_q.size() > 0) c = ctrl_q.pop_front();
                g = gen;
                if (!hang) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    @(posedge clk);
                    #1 busy = 1;
                    repeat ($urandom_range(1, 5)) @(posedge clk);
                    #1 busy = 0;
                    if (g == gen && !c[16])
                        for (int i = 0; i < int'(c[15:0]) / 8; i++) begin
                            d = $urandom_range(0, 255);
                            rxq.push_back(8'(d));
                            exp_rx.push_back(8'(d));
                        end
                end
            end
        end
    end

    initial begin : rx_fifo
        bit rd_s;
        forever begin
            @(negedge clk);
            rd_s = rd && rst;
            @(posedge clk);
            #1;
            if (rd_s && rxq.size() > 0) rdata = rxq.pop_front();
            empty = rxq.size() == 0 || (emp_rand && $urandom_range(0, 1) == 1);
        end
    end

    initial begin : tx_full
        forever begin
            @(posedge clk);
            #1;
            if (full_rand) full = $urandom_range(0, 3) == 0;
        end
    end

    initial begin : monitor
        logic [7:0]  b;
        logic [16:0] w;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (wr) begin
                    if (exp_wr.size() == 0) fail("wr_unexpected");
                    else begin
                        b = exp_wr.pop_front();
                        chk("wdata", wdata, b);
                    end
                end
                if (full) chk("wr_while_full", wr, 0);
                if (rd) begin
                    rd_cnt++;
                    chk("rd_while_empty", empty, 0);
                end
                if (work) begin
                    work_cnt++;
                    work_cyc = cyc;
                    if (exp_work.size() == 0) fail("work_unexpected");
                    else begin
                        w = exp_work.pop_front();
                        chk("work_op_len", {op, len}, w);
                    end
                end
                if (rx_valid) begin
                    if (exp_rx.size() == 0) fail("rx_unexpected");
                    else begin
                        b = exp_rx.pop_front();
                        chk("rx_data", rx_data, b);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int s, n, ecyc, wc;
        #12;
        chk_reset("por");
        @(negedge clk);
        rst = 1;
        repeat (5) @(negedge clk);
        chk("no_autostart_work", work_cnt, 0);
        chk("no_autostart_wr", wr, 0);
        chk("idle_done", done, 0);

        // plain sequence, plus a start pulse mid-run that must be ignored
        expect_all();
        pulse_start();
        wait_work(1, 200);
        pulse_start();
        wait_end("t1", 3000);
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);
        chk_drained("t1");

        // TX FIFO full for three cycles in the middle of entry1, with RX empty flickering
        emp_rand = 1;
        expect_all();
        s = rd_cnt;
        pulse_start();
        n = 0;
        while (!(cmd_idx == 1 && wr && wdata == 8'h19) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail("t2_no_entry1_push");
        @(posedge clk);
        #1 full = 1;
        repeat (3) begin
            @(negedge clk);
            chk("t2_hold_wdata", wdata, 8'h04);
        end
        @(posedge clk);
        #1 full = 0;
        wait_end("t2", 3000);
        chk("t2_done", done, 1);
        chk("t2_reads", rd_cnt - s, 10);
        chk_drained("t2");

        // random full / empty / busy timing
        full_rand = 1;
        repeat (2) begin
            expect_all();
            pulse_start();
            wait_end("t3", 4000);
            chk("t3_done", done, 1);
            chk_drained("t3");
        end
        full_rand = 0;
        @(posedge clk);
        #1 full = 0;

        // busy never rises: timeout into error, then recover
        hang = 1;
        expect_entry(0);
        s = work_cnt;
        pulse_start();
        wait_work(s + 1, 200);
        wc = work_cyc;
        n = 0;
        while (!err && n < TMO + 50) begin
            @(negedge clk);
            n++;
        end
        ecyc = cyc;
        chk("tmo_err", err, 1);
        chk("tmo_latency", ecyc - wc, TMO + 2);
        chk("tmo_wr", wr, 0);
        chk("tmo_rd", rd, 0);
        chk("tmo_work", work, 0);
        chk_drained("tmo");
        hang = 0;
        expect_all();
        pulse_start();
        wait_end("rec", 3000);
        chk("rec_done", done, 1);
        chk("rec_err", err, 0);
        chk_drained("rec");

        // loop back to entry0, then reset while waiting for busy to fall
        loop_en = 1;
        expect_all();
        expect_entry(0);
        pulse_start();
        n = 0;
        while (exp_wr.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail("loop_timeout");
        chk("loop_idx", cmd_idx, 0);
        chk("loop_done", done, 0);
        n = 0;
        while (!(busy && exp_work.size() == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail("loop_busy_timeout");
        @(posedge clk);
        #2;
        gen++;
        rst = 0;
        loop_en = 0;
        #1;
        chk_reset("midrst");
        repeat (10) @(negedge clk);
        exp_rx.delete();
        rxq.delete();
        ctrl_q.delete();
        rst = 1;
        s = work_cnt;
        repeat (30) @(negedge clk);
        chk("midrst_no_work", work_cnt - s, 0);
        chk("midrst_idle_done", done, 0);
        expect_all();
        pulse_start();
        wait_end("fin", 3000);
        chk("fin_done", done, 1);
        chk_drained("fin");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_seq_fsm.md
SPI_SEQ_FSM -- requirements
Module: spi_seq_fsm

Interface
REQ-001 Parameter DATA, default 8: FIFO byte width in bits.
REQ-002 Parameter NCMD, default 3: number of command-table entries.
REQ-003 Parameter MAXB, default 8: maximum TX bytes per command.
REQ-004 Parameter TMO, default 1024: busy timeout in clk cycles.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle pulse; starts the sequence from entry 0.
REQ-008 loop_en  input  1  restart at entry 0 after the last entry instead of stopping.
REQ-009 len  output  16  transfer length in bits to the SPI controller.
REQ-010 op  output  1  transfer mode: 1 = write, 0 = read.
REQ-011 work  output  1  one-cycle launch strobe to the SPI controller.
REQ-012 busy  input  1  SPI controller busy.
REQ-013 wdata  output  DATA  TX FIFO write data.
REQ-014 wr  output  1  TX FIFO write strobe.
REQ-015 full  input  1  TX FIFO full.
REQ-016 rdata  input  DATA  RX FIFO read data, valid one cycle after rd.
REQ-017 rd  output  1  RX FIFO read strobe.
REQ-018 empty  input  1  RX FIFO empty.
REQ-019 rx_data  output  DATA  captured RX byte.
REQ-020 rx_valid  output  1  one-cycle qualifier for rx_data.
REQ-021 cmd_idx  output  $clog2(NCMD)  index of the active entry.
REQ-022 done  output  1  high in ST_DONE until the next start.
REQ-023 err  output  1  high in ST_ERR until the next start.

Function
REQ-024 Each table entry SHALL hold: op; len (16 bit); nbytes (1..MAXB); MAXB bytes.
REQ-025 States: ST_IDLE, ST_PUSH, ST_LAUNCH, ST_WAIT_HI, ST_WAIT_LO, ST_DRAIN, ST_NEXT, ST_DONE, ST_ERR.
REQ-026 ST_IDLE/ST_DONE/ST_ERR + start -> ST_PUSH with cmd_idx=0, byte counter=0, done=0, err=0.
REQ-027 ST_PUSH: wr=1 with wdata=byte[counter] only in cycles where full=0; counter increments on each write.
REQ-028 When full=1, wr SHALL be 0 and wdata/counter SHALL hold.
REQ-029 After byte nbytes-1 is written -> ST_LAUNCH.
REQ-030 ST_LAUNCH is entered only when busy=0, and SHALL last exactly one cycle: work=1, op/len from the entry.
REQ-031 op/len SHALL stay stable from ST_LAUNCH until the next entry's launch.
REQ-032 ST_LAUNCH -> ST_WAIT_HI; busy=1 -> ST_WAIT_LO.
REQ-033 ST_WAIT_LO: busy=0 -> ST_DRAIN if op=0, else ST_NEXT.
REQ-034 ST_WAIT_HI and ST_WAIT_LO each load a cycle counter; if it reaches TMO -> ST_ERR.
REQ-035 ST_DRAIN: rd=1 in each cycle where empty=0 and fewer than len/DATA reads have been issued.
REQ-036 rx_data<=rdata with rx_valid=1 exactly one cycle after each rd.
REQ-037 After the last rx_valid -> ST_NEXT; ST_DRAIN is also bounded by TMO.
REQ-038 len not a multiple of DATA: read count is floor(len/DATA); len<DATA means zero reads, ST_DRAIN -> ST_NEXT directly.
REQ-039 ST_NEXT, entry is not the last: cmd_idx+1 -> ST_PUSH.
REQ-040 ST_NEXT, last entry: cmd_idx wraps to 0 -> ST_PUSH if loop_en=1, else ST_DONE.
REQ-041 start outside ST_IDLE/ST_DONE/ST_ERR SHALL be ignored.
REQ-042 loop_en SHALL be sampled only in ST_NEXT.

Reset
REQ-043 rst=0 SHALL asynchronously force ST_IDLE and clear all counters, even mid-transfer.
REQ-044 Reset values: len=0, op=0, work=0, wdata=0, wr=0, rd=0, rx_data=0, rx_valid=0, cmd_idx=0, done=0, err=0.
REQ-045 Reset release SHALL not start a sequence; start is required.

Structure
REQ-046 Package spi_seq_pkg SHALL hold the state enum, the entry struct (op, len, nbytes, bytes) and default constants.
REQ-047 Sub-module spi_seq_rom SHALL return the entry for cmd_idx combinationally.
REQ-048 Default table: entry0 = read, len 40, bytes 00 19 00; entry1 = write, len 40, bytes 00 19 04 0f a0; entry2 = read, len 40, bytes 00 19 00.

Verification
REQ-049 start, full=0, bench busy model: wr bytes 00,19,00 -> work with op=0, len=40 -> 5 rx_valid -> entry1 bytes 00,19,04,0f,a0 with op=1 -> entry2 -> done=1.
REQ-050 full=1 held 3 cycles mid-push of entry1: wr=0 for those cycles, then byte 04 written once, no loss or duplicate.
REQ-051 busy never rises after work: err=1 at TMO+2 cycles after work, wr/rd/work=0; next start recovers.
REQ-052 loop_en=1: after entry2, cmd_idx=0 and entry0 is pushed again with done=0.
REQ-053 empty toggling during ST_DRAIN: rd only when empty=0, exactly 5 reads, rx_data matches FIFO order.
REQ-054 rst=0 during ST_WAIT_LO: all outputs at reset values in the same cycle; no work until the next start.
